// File: rtl/sm83_seq_pkg.sv
// Shared types and phase encodings for the SM83 M-cycle/T-state sequencer.
package sm83_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_RESET     = 2'd0,
        SEQ_RUN       = 2'd1,
        SEQ_HALT_STOP = 2'd2,
        SEQ_WAKE      = 2'd3
    } seq_state_t;

    localparam logic [3:0] T_NONE = 4'b0000;
    localparam logic [3:0] T1     = 4'b0001;
    localparam logic [3:0] T2     = 4'b0010;
    localparam logic [3:0] T3     = 4'b0100;
    localparam logic [3:0] T4     = 4'b1000;

    // Plain ring advance; wait-state stretching of T3 is handled by the caller.
    function automatic logic [3:0] next_phase(input logic [3:0] p);
        logic [3:0] n;
        n = T1;
        case (p)
            T1:      n = T2;
            T2:      n = T3;
            T3:      n = T4;
            T4:      n = T1;
            default: n = T1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sm83_wake_timer.sv
// Loadable down-counter that times the STOP wake-up delay; saturates at zero.
module sm83_wake_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sm83_mcycle_seq.sv
// SM83 sequencer: one-hot T1..T4 strobes, M-cycle count, T3 wait stretch,
// and HALT/STOP entry with immediate (HALT) or delayed (STOP) wake-up.
module sm83_mcycle_seq
    import sm83_seq_pkg::*;
#(
    parameter int MCYCLE_MAX      = 6,
    parameter int STOP_WAKE_DELAY = 16,
    localparam int MW = (MCYCLE_MAX > 1) ? $clog2(MCYCLE_MAX) : 1,
    localparam int CW = (STOP_WAKE_DELAY > 1) ? $clog2(STOP_WAKE_DELAY) : 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          wait_req,
    input  logic          last_mcycle,
    input  logic          halt_req,
    input  logic          stop_req,
    input  logic          wake,
    output logic [3:0]    t_phase,
    output logic [MW-1:0] m_cycle,
    output logic          fetch_cycle,
    output seq_state_t    seq_state,
    output logic          overrun
);

    seq_state_t    state_q, state_d;
    logic [3:0]    phase_q, phase_d;
    logic [MW-1:0] m_q, m_d;
    logic          fetch_q, fetch_d;
    logic          ovr_q, ovr_d;
    logic          stop_flag_q, stop_flag_d;
    logic          tmr_load, tmr_en, tmr_zero;

    sm83_wake_timer #(
        .W(CW)
    ) u_wake_timer (
        .clk    (clk),
        .nreset (nreset),
        .load   (tmr_load),
        .en     (tmr_en),
        .value  (CW'(STOP_WAKE_DELAY - 1)),
        .zero   (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        m_d         = m_q;
        fetch_d     = fetch_q;
        ovr_d       = ovr_q;
        stop_flag_d = stop_flag_q;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            SEQ_RESET: begin
                state_d = SEQ_RUN;
                phase_d = T1;
                m_d     = '0;
                fetch_d = 1'b1;
            end

            SEQ_RUN: begin
                if (phase_q == T3 && wait_req) begin
                    phase_d = T3;
                end else begin
                    phase_d = next_phase(phase_q);
                end

                // Instruction-boundary decisions happen only on the edge leaving T4.
                if (phase_q == T4) begin
                    if (!last_mcycle) begin
                        if (m_q == MW'(MCYCLE_MAX - 1)) begin
                            ovr_d = 1'b1;
                        end else begin
                            m_d = m_q + MW'(1);
                        end
                        fetch_d = (m_d == '0);
                    end else begin
                        m_d     = '0;
                        fetch_d = 1'b1;
                        if (stop_req || (halt_req && !wake)) begin
                            state_d     = SEQ_HALT_STOP;
                            stop_flag_d = stop_req;
                            phase_d     = T_NONE;
                            fetch_d     = 1'b0;
                        end
                    end
                end
            end

            SEQ_HALT_STOP: begin
                if (wake) begin
                    if (stop_flag_q) begin
                        state_d  = SEQ_WAKE;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = SEQ_RUN;
                        phase_d = T1;
                        m_d     = '0;
                        fetch_d = 1'b1;
                    end
                end
            end

            SEQ_WAKE: begin
                if (tmr_zero) begin
                    state_d     = SEQ_RUN;
                    stop_flag_d = 1'b0;
                    phase_d     = T1;
                    m_d         = '0;
                    fetch_d     = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            default: begin
                state_d = SEQ_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= SEQ_RESET;
            phase_q     <= T_NONE;
            m_q         <= '0;
            fetch_q     <= 1'b0;
            ovr_q       <= 1'b0;
            stop_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            m_q         <= m_d;
            fetch_q     <= fetch_d;
            ovr_q       <= ovr_d;
            stop_flag_q <= stop_flag_d;
        end
    end

    assign t_phase     = phase_q;
    assign m_cycle     = m_q;
    assign fetch_cycle = fetch_q;
    assign seq_state   = state_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_sm83_mcycle_seq.sv
// Directed bench for sm83_mcycle_seq: vector table for phase/M-cycle/wait behaviour,
// hand-written sequences for HALT, STOP wake delay, overrun and async reset.
module tb_sm83_mcycle_seq;
    import sm83_seq_pkg::*;

    logic       clk;
    logic       nreset;
    logic       wait_req, last_mcycle, halt_req, stop_req, wake;
    logic [3:0] t_phase;
    logic [2:0] m_cycle;
    logic       fetch_cycle;
    seq_state_t seq_state;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic       w, l, h, s, k;
        logic [3:0] ph;
        logic [2:0] m;
        logic       f;
    } vec_t;

    vec_t tbl[$];

    sm83_mcycle_seq dut (
        .clk         (clk),
        .nreset      (nreset),
        .wait_req    (wait_req),
        .last_mcycle (last_mcycle),
        .halt_req    (halt_req),
        .stop_req    (stop_req),
        .wake        (wake),
        .t_phase     (t_phase),
        .m_cycle     (m_cycle),
        .fetch_cycle (fetch_cycle),
        .seq_state   (seq_state),
        .overrun     (overrun)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ph, input logic [2:0] m,
                           input logic f, input seq_state_t st, input logic ov);
        chk({tag, ".t_phase"}, 8'(t_phase), 8'(ph));
        chk({tag, ".m_cycle"}, 8'(m_cycle), 8'(m));
        chk({tag, ".fetch"}, 8'(fetch_cycle), 8'(f));
        chk({tag, ".state"}, 8'(seq_state), 8'(st));
        chk({tag, ".overrun"}, 8'(overrun), 8'(ov));
    endtask

    // Drive inputs, let one active edge pass, return at the following negedge.
    task automatic step(input logic w, input logic l, input logic h, input logic s, input logic k);
        wait_req    = w;
        last_mcycle = l;
        halt_req    = h;
        stop_req    = s;
        wake        = k;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        nreset = 1'b0;
        wait_req = 1'b0; last_mcycle = 1'b0; halt_req = 1'b0; stop_req = 1'b0; wake = 1'b0;

        // Steady fetch loop with last_mcycle=1
        for (int i = 0; i < 2; i++) begin
            tbl.push_back({5'b01000, T1, 3'd0, 1'b1});
            tbl.push_back({5'b01000, T2, 3'd0, 1'b1});
            tbl.push_back({5'b01000, T3, 3'd0, 1'b1});
            tbl.push_back({5'b01000, T4, 3'd0, 1'b1});
        end
        // Three-M-cycle instruction
        tbl.push_back({5'b00000, T1, 3'd1, 1'b0});
        tbl.push_back({5'b00000, T2, 3'd1, 1'b0});
        tbl.push_back({5'b00000, T3, 3'd1, 1'b0});
        tbl.push_back({5'b00000, T4, 3'd1, 1'b0});
        tbl.push_back({5'b00000, T1, 3'd2, 1'b0});
        tbl.push_back({5'b00000, T2, 3'd2, 1'b0});
        tbl.push_back({5'b00000, T3, 3'd2, 1'b0});
        tbl.push_back({5'b00000, T4, 3'd2, 1'b0});
        tbl.push_back({5'b01000, T1, 3'd0, 1'b1});
        // T3 stretched by three wait edges
        tbl.push_back({5'b01000, T2, 3'd0, 1'b1});
        tbl.push_back({5'b01000, T3, 3'd0, 1'b1});
        tbl.push_back({5'b11000, T3, 3'd0, 1'b1});
        tbl.push_back({5'b11000, T3, 3'd0, 1'b1});
        tbl.push_back({5'b11000, T3, 3'd0, 1'b1});
        tbl.push_back({5'b01000, T4, 3'd0, 1'b1});
        tbl.push_back({5'b01000, T1, 3'd0, 1'b1});
        // wait/halt/stop outside their sampling phase must be ignored
        tbl.push_back({5'b11110, T2, 3'd0, 1'b1});
        tbl.push_back({5'b11110, T3, 3'd0, 1'b1});
        tbl.push_back({5'b01000, T4, 3'd0, 1'b1});
        tbl.push_back({5'b11000, T1, 3'd0, 1'b1});

        @(negedge clk);
        chk_all("reset", T_NONE, 3'd0, 1'b0, SEQ_RESET, 1'b0);
        nreset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].w, tbl[i].l, tbl[i].h, tbl[i].s, tbl[i].k);
            chk($sformatf("vec%0d.t_phase", i), 8'(t_phase), 8'(tbl[i].ph));
            chk($sformatf("vec%0d.m_cycle", i), 8'(m_cycle), 8'(tbl[i].m));
            chk($sformatf("vec%0d.fetch", i), 8'(fetch_cycle), 8'(tbl[i].f));
            chk($sformatf("vec%0d.state", i), 8'(seq_state), 8'(SEQ_RUN));
        end

        // HALT entry and zero-latency wake
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        chk("pre_halt.t_phase", 8'(t_phase), 8'(T4));
        step(0, 1, 1, 0, 0);
        chk_all("halt_entry", T_NONE, 3'd0, 1'b0, SEQ_HALT_STOP, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk_all("halt_hold", T_NONE, 3'd0, 1'b0, SEQ_HALT_STOP, 1'b0);
        end
        step(0, 0, 0, 0, 1);
        chk_all("halt_wake", T1, 3'd0, 1'b1, SEQ_RUN, 1'b0);

        // halt_req with wake already pending: no HALT
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1);
        chk_all("halt_wake_pend", T1, 3'd0, 1'b1, SEQ_RUN, 1'b0);

        // STOP beats HALT, then a one-clock wake pulse starts the delay
        step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        chk_all("stop_entry", T_NONE, 3'd0, 1'b0, SEQ_HALT_STOP, 1'b0);
        step(0, 0, 0, 0, 0);
        chk_all("stop_hold", T_NONE, 3'd0, 1'b0, SEQ_HALT_STOP, 1'b0);
        step(0, 0, 0, 0, 1);
        chk_all("stop_wake", T_NONE, 3'd0, 1'b0, SEQ_WAKE, 1'b0);
        for (int k = 1; k < 16; k++) exp_q.push_back(8'(T_NONE));
        exp_q.push_back(8'(T1));
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("wake_delay%0d.t_phase", k), 8'(t_phase), exp_q.pop_front());
            chk($sformatf("wake_delay%0d.state", k), 8'(seq_state),
                8'((k == 16) ? SEQ_RUN : SEQ_WAKE));
        end
        chk("wake_done.fetch", 8'(fetch_cycle), 8'(1'b1));

        // Overrun: six instruction-continuing M-cycle ends from m_cycle=0
        for (int mc = 1; mc <= 6; mc++) begin
            step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            chk_all($sformatf("ovr_m%0d", mc), T1, (mc < 6) ? 3'(mc) : 3'd5, 1'b0,
                    SEQ_RUN, (mc == 6) ? 1'b1 : 1'b0);
        end
        step(0, 0, 0, 0, 0);
        chk_all("ovr_t2", T2, 3'd5, 1'b0, SEQ_RUN, 1'b1);

        // Asynchronous reset in the middle of T2
        #2 nreset = 1'b0;
        #1 chk_all("async_reset", T_NONE, 3'd0, 1'b0, SEQ_RESET, 1'b0);
        @(negedge clk);
        chk_all("reset_held", T_NONE, 3'd0, 1'b0, SEQ_RESET, 1'b0);
        nreset = 1'b1;
        step(0, 1, 0, 0, 0);
        chk_all("reset_exit", T1, 3'd0, 1'b1, SEQ_RUN, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
